// File: rtl/serdes_pkg.sv
// Shared types and constants for the link transmit serializer.
package serdes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_PRE,
    ST_DATA
  } fs_state_e;

  typedef struct packed {
    fs_state_e state;
    logic      last_bit;
  } fs_dbg_t;

  localparam logic [7:0] COMMA_DEFAULT = 8'h3C;
  localparam logic       KCODE         = 1'b1;

  function automatic int sym_w(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/sym_shifter.sv
// Symbol shifter: loads one symbol at the boundary and sends it LSB first,
// one bit per cycle, with first-bit and last-bit strobes.
module sym_shifter #(
  parameter  int SYM_W = 9,
  localparam int BIT_W = $clog2(SYM_W)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [SYM_W-1:0] sym_i,
  output logic             data_o,
  output logic             ena_o,
  output logic             last_o,
  output logic [BIT_W-1:0] bit_cnt_o
);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SYM_W - 1);

  logic [SYM_W-1:0] shreg_q;

  // bit_cnt_o is the index of the bit driven onto the line at the next edge;
  // zero marks the boundary where the next symbol is loaded.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shreg_q   <= '0;
      bit_cnt_o <= '0;
      data_o    <= 1'b0;
      ena_o     <= 1'b0;
      last_o    <= 1'b0;
    end else if (load_i) begin
      shreg_q   <= sym_i >> 1;
      data_o    <= sym_i[0];
      ena_o     <= 1'b1;
      last_o    <= 1'b0;
      bit_cnt_o <= BIT_W'(1);
    end else begin
      shreg_q   <= shreg_q >> 1;
      data_o    <= shreg_q[0];
      ena_o     <= 1'b0;
      last_o    <= (bit_cnt_o == LAST_BIT);
      bit_cnt_o <= (bit_cnt_o == LAST_BIT) ? '0 : bit_cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/frame_serializer.sv
// Frame serializer: accepts a frame of symbols and sends comma preamble plus
// data symbols on a continuous serial line, idle commas in between.
module frame_serializer
  import serdes_pkg::*;
#(
  parameter  int                NUM_SYMS   = 3,
  parameter  int                DATA_W     = 8,
  parameter  int                NUM_COMMAS = 1,
  parameter  logic [DATA_W-1:0] COMMA      = DATA_W'(COMMA_DEFAULT),
  localparam int                SYM_W      = sym_w(DATA_W)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [NUM_SYMS*SYM_W-1:0] data_i,
  output logic                      data_o,
  output logic                      ena_o,
  output logic                      busy_o,
  output logic                      done_o,
  output fs_dbg_t                   dbg_o
);

  localparam int MAX_N = (NUM_SYMS > NUM_COMMAS) ? NUM_SYMS : NUM_COMMAS;
  localparam int SC_W  = $clog2(MAX_N + 1);
  localparam int BIT_W = $clog2(SYM_W);

  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(SYM_W - 1);
  localparam logic [SC_W-1:0]  LAST_PRE  = SC_W'(NUM_COMMAS - 1);
  localparam logic [SC_W-1:0]  LAST_SYM  = SC_W'(NUM_SYMS - 1);
  localparam logic [SYM_W-1:0] COMMA_SYM = {KCODE, COMMA};

  if (NUM_SYMS < 1 || NUM_COMMAS < 1 || DATA_W < 1) begin : g_param_check
    $error("frame_serializer: NUM_SYMS, NUM_COMMAS and DATA_W must all be >= 1");
  end

  // Handshake: a frame transfers on the rising edge where valid_i && ready_o;
  // valid_i without ready_o is ignored and data_i may change after transfer.
  fs_state_e                 state_q, state_d;
  logic [SC_W-1:0]           sym_q, sym_d;
  logic [NUM_SYMS*SYM_W-1:0] frame_q;
  logic [BIT_W-1:0]          bit_cnt;
  logic [SYM_W-1:0]          next_sym;
  logic                      boundary, accept, done_d, last_bit;

  assign boundary = (bit_cnt == '0);
  assign accept   = valid_i && ready_o;

  always_comb begin
    state_d  = state_q;
    sym_d    = sym_q;
    next_sym = COMMA_SYM;
    done_d   = (state_q == ST_DATA) && (sym_q == LAST_SYM) && (bit_cnt == LAST_BIT);
    case (state_q)
      ST_IDLE: begin
        // Accepting on the boundary skips ARMED: the preamble follows at once.
        if (accept) state_d = boundary ? ST_PRE : ST_ARMED;
      end
      ST_ARMED: begin
        if (boundary) state_d = ST_PRE;
      end
      ST_PRE: begin
        if (boundary) begin
          if (sym_q == LAST_PRE) state_d = ST_DATA;
          else                   sym_d   = sym_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (boundary) begin
          if (sym_q == LAST_SYM) state_d = ST_IDLE;
          else                   sym_d   = sym_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) sym_d = '0;
    // sym_d is the index of the symbol being loaded at this boundary.
    if (state_d == ST_DATA) begin
      for (int i = 0; i < NUM_SYMS; i++) begin
        if (sym_d == SC_W'(i)) next_sym = frame_q[i*SYM_W +: SYM_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      sym_q   <= '0;
      ready_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      ready_o <= (state_d == ST_IDLE);
      busy_o  <= (state_d != ST_IDLE);
      done_o  <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && accept) frame_q <= data_i;
  end

  sym_shifter #(
    .SYM_W(SYM_W)
  ) u_shifter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (boundary),
    .sym_i    (next_sym),
    .data_o   (data_o),
    .ena_o    (ena_o),
    .last_o   (last_bit),
    .bit_cnt_o(bit_cnt)
  );

  assign dbg_o = '{state: state_q, last_bit: last_bit};

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer: default instance plus a
// NUM_SYMS=5 / DATA_W=10 / NUM_COMMAS=2 instance sharing clock and reset.
module tb_frame_serializer;
  import serdes_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid1, valid2;
  logic [26:0] data1;
  logic [54:0] data2;
  logic        d1_ready, d1_data, d1_ena, d1_busy, d1_done;
  logic        d2_ready, d2_data, d2_ena, d2_busy, d2_done;
  fs_dbg_t     d1_dbg, d2_dbg;

  int total = 0;
  int bad   = 0;

  logic        line_a[128];
  logic        ena_a[128];
  logic        done_a[128];
  logic        busy_a[128];
  logic        rdy_a[128];
  logic [54:0] frm_q[$];
  logic [15:0] exp_q[$];
  int          acc_idx[4];
  int          acc_n;

  always #5 clk = ~clk;

  frame_serializer dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .valid_i(valid1),
    .ready_o(d1_ready),
    .data_i (data1),
    .data_o (d1_data),
    .ena_o  (d1_ena),
    .busy_o (d1_busy),
    .done_o (d1_done),
    .dbg_o  (d1_dbg)
  );

  frame_serializer #(
    .NUM_SYMS  (5),
    .DATA_W    (10),
    .NUM_COMMAS(2)
  ) dut2 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .valid_i(valid2),
    .ready_o(d2_ready),
    .data_i (data2),
    .data_o (d2_data),
    .ena_o  (d2_ena),
    .busy_o (d2_busy),
    .done_o (d2_done),
    .dbg_o  (d2_dbg)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int which, input logic v, input logic [54:0] d);
    if (which == 1) begin
      valid2 = v;
      data2  = d;
    end else begin
      valid1 = v;
      data1  = d[26:0];
    end
  endtask

  // Samples one DUT every negedge into the capture arrays while feeding
  // frames from frm_q; optionally pulses reset low for rst_len cycles.
  task automatic cap(input int which, input int n, input int start_at,
                     input int rst_at, input int rst_len);
    logic v_now, r_now, pend;
    pend  = 1'b0;
    acc_n = 0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (which == 1) begin
        line_a[j] = d2_data; ena_a[j] = d2_ena; done_a[j] = d2_done;
        busy_a[j] = d2_busy; rdy_a[j] = d2_ready;
        v_now = valid2;
      end else begin
        line_a[j] = d1_data; ena_a[j] = d1_ena; done_a[j] = d1_done;
        busy_a[j] = d1_busy; rdy_a[j] = d1_ready;
        v_now = valid1;
      end
      r_now = rdy_a[j];
      if (pend) begin
        pend = 1'b0;
        if (frm_q.size() > 0) drive(which, 1'b1, frm_q[0]);
        else drive(which, 1'b0, 55'({$urandom_range(32'h7fff_ffff, 0), $urandom_range(32'h7fff_ffff, 0)}));
      end
      if (j == rst_at) rst_n = 1'b0;
      if (j == rst_at + rst_len) rst_n = 1'b1;
      if (j == start_at && frm_q.size() > 0) begin
        drive(which, 1'b1, frm_q[0]);
        v_now = 1'b1;
      end
      if (v_now && r_now && rst_n && frm_q.size() > 0) begin
        pend = 1'b1;
        if (acc_n < 4) acc_idx[acc_n] = j;
        acc_n++;
        void'(frm_q.pop_front());
      end
    end
  endtask

  task automatic wait_sync(input int which);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = (which == 1) ? d2_ena : d1_ena;
    end
    check_eq("sync", 64'(seen), 64'(1));
  endtask

  function automatic logic [15:0] sym_at(input int start, input int w);
    logic [15:0] v;
    v = '0;
    for (int b = 0; b < w; b++) v[b] = line_a[start + b];
    return v;
  endfunction

  function automatic int cnt(input int sel, input int a, input int b);
    int c;
    c = 0;
    for (int j = a; j <= b; j++) begin
      case (sel)
        0: c += int'(done_a[j]);
        1: c += int'(busy_a[j]);
        2: c += int'(ena_a[j]);
        default: c += int'(rdy_a[j]);
      endcase
    end
    return c;
  endfunction

  task automatic check_syms(input string tag, input int start, input int w);
    int k;
    k = 0;
    while (exp_q.size() > 0) begin
      check_eq(tag, 64'(sym_at(start + k * w, w)), 64'(exp_q.pop_front()));
      k++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    valid1 = 1'b0;
    valid2 = 1'b0;
    data1  = '0;
    data2  = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    check_eq("rst_data", 64'(d1_data), 64'(0));
    check_eq("rst_ena", 64'(d1_ena), 64'(0));
    check_eq("rst_ready", 64'(d1_ready), 64'(0));
    check_eq("rst_busy", 64'(d1_busy), 64'(0));
    check_eq("rst_done", 64'(d1_done), 64'(0));
    check_eq("rst_state", 64'(d1_dbg.state), 64'(ST_IDLE));

    // Idle line after release: 0x13C repeated, strobe every 9 cycles.
    rst_n = 1'b1;
    cap(0, 45, -1, -1, 0);
    for (int s = 0; s < 5; s++) exp_q.push_back(16'h13C);
    check_syms("idle_sym", 0, 9);
    check_eq("idle_ena0", 64'(ena_a[0]), 64'(1));
    check_eq("idle_ena_cnt", 64'(cnt(2, 0, 44)), 64'(5));
    check_eq("idle_ready_cnt", 64'(cnt(3, 0, 44)), 64'(45));
    check_eq("idle_busy_cnt", 64'(cnt(1, 0, 44)), 64'(0));

    // Single frame accepted at bit 3 of an idle comma (j=2); preamble at j=8.
    wait_sync(0);
    frm_q.push_back(55'({9'h0AA, 9'h055, 9'h1BC}));
    cap(0, 60, 2, -1, 0);
    check_eq("sf_acc_cnt", 64'(acc_n), 64'(1));
    check_eq("sf_ena_gap", 64'(cnt(2, 3, 7)), 64'(0));
    check_eq("sf_ena_pre", 64'(ena_a[8]), 64'(1));
    exp_q.push_back(16'h13C);
    exp_q.push_back(16'h1BC);
    exp_q.push_back(16'h055);
    exp_q.push_back(16'h0AA);
    check_syms("sf_sym", 8, 9);
    check_eq("sf_done_at", 64'(done_a[43]), 64'(1));
    check_eq("sf_done_cnt", 64'(cnt(0, 0, 59)), 64'(1));
    check_eq("sf_busy_first", 64'(busy_a[3]), 64'(1));
    check_eq("sf_busy_cnt", 64'(cnt(1, 0, 59)), 64'(41));
    check_eq("sf_ready_after", 64'(rdy_a[44]), 64'(1));

    // Backpressure: two frames with valid held; B accepted right after done.
    wait_sync(0);
    frm_q.push_back(55'({9'h011, 9'h122, 9'h033}));
    frm_q.push_back(55'({9'h1FB, 9'h0C3, 9'h05A}));
    cap(0, 100, 0, -1, 0);
    check_eq("bp_acc_cnt", 64'(acc_n), 64'(2));
    check_eq("bp_acc_a", 64'(acc_idx[0]), 64'(0));
    check_eq("bp_acc_b", 64'(acc_idx[1]), 64'(44));
    exp_q.push_back(16'h13C);
    exp_q.push_back(16'h033);
    exp_q.push_back(16'h122);
    exp_q.push_back(16'h011);
    check_syms("bp_sym_a", 8, 9);
    check_eq("bp_gap_ena", 64'(ena_a[44]), 64'(1));
    check_eq("bp_gap_sym", 64'(sym_at(44, 9)), 64'(16'h13C));
    exp_q.push_back(16'h13C);
    exp_q.push_back(16'h05A);
    exp_q.push_back(16'h0C3);
    exp_q.push_back(16'h1FB);
    check_syms("bp_sym_b", 53, 9);
    check_eq("bp_done_a", 64'(done_a[43]), 64'(1));
    check_eq("bp_done_b", 64'(done_a[88]), 64'(1));
    check_eq("bp_done_cnt", 64'(cnt(0, 0, 99)), 64'(2));
    check_eq("kflag_bit", 64'(line_a[88]), 64'(1));

    // Reset pulse of 2 cycles during data symbol 1.
    wait_sync(0);
    frm_q.push_back(55'({9'h0F0, 9'h00F, 9'h0FF}));
    cap(0, 60, 0, 28, 2);
    check_eq("mr_sym0", 64'(sym_at(17, 9)), 64'(16'h0FF));
    check_eq("mr_out29", 64'({line_a[29], ena_a[29], rdy_a[29], busy_a[29], done_a[29]}), 64'(0));
    check_eq("mr_out30", 64'({line_a[30], ena_a[30], rdy_a[30], busy_a[30], done_a[30]}), 64'(0));
    check_eq("mr_restart_ena", 64'(ena_a[31]), 64'(1));
    check_eq("mr_restart_sym", 64'(sym_at(31, 9)), 64'(16'h13C));
    check_eq("mr_next_ena", 64'(ena_a[40]), 64'(1));
    check_eq("mr_ready", 64'(rdy_a[31]), 64'(1));
    check_eq("mr_busy_cnt", 64'(cnt(1, 31, 59)), 64'(0));
    check_eq("mr_done_cnt", 64'(cnt(0, 0, 59)), 64'(0));

    // Parametrised instance: 2 commas then 5 x 11-bit symbols, 77 cycles.
    wait_sync(1);
    frm_q.push_back({11'h005, 11'h004, 11'h003, 11'h002, 11'h001});
    cap(1, 100, 0, -1, 0);
    check_eq("p_acc_cnt", 64'(acc_n), 64'(1));
    check_eq("p_ena_pre", 64'(ena_a[10]), 64'(1));
    exp_q.push_back(16'h43C);
    exp_q.push_back(16'h43C);
    for (int s = 1; s <= 5; s++) exp_q.push_back(16'(s));
    check_syms("p_sym", 10, 11);
    check_eq("p_done_at", 64'(done_a[86]), 64'(1));
    check_eq("p_done_cnt", 64'(cnt(0, 0, 99)), 64'(1));
    check_eq("p_busy_cnt", 64'(cnt(1, 0, 99)), 64'(86));
    check_eq("p_state", 64'(d2_dbg.state), 64'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_serializer.md
# frame_serializer

Parametrised frame serializer for the high-speed link transmit path. Accepts a frame of `NUM_SYMS` symbols (each a K-flag plus `DATA_W` data bits) over a valid/ready handshake. Emits the frame as a continuous bit stream: a comma preamble, then the data symbols. The line carries idle commas whenever no frame is in flight. It supersedes the fixed three-symbol input serializer; it adds variable frame length, a configurable preamble, backpressure and frame-done signalling.

## Interface
- `NUM_SYMS`, 3, data symbols per frame (≥1)
- `DATA_W`, 8, data bits per symbol; symbol width `SYM_W = DATA_W+1`
- `NUM_COMMAS`, 1, comma symbols in each frame preamble (≥1)
- `COMMA`, 8'h3C, idle/preamble data byte, always sent with K=1 (width `DATA_W`)
- `clk_i` in 1: single clock
- `rst_ni` in 1: reset, synchronous and active-low
- `valid_i` in 1: frame on `data_i` is valid
- `ready_o` out 1: block can accept a frame
- `data_i` in `NUM_SYMS*SYM_W`: symbol i occupies bits `[i*SYM_W +: SYM_W]`; the MSB of each symbol is K (1 = control code)
- `data_o` out 1: serial line
- `ena_o` out 1: one-cycle strobe on the first bit of every symbol
- `busy_o` out 1: a frame is accepted or in flight
- `done_o` out 1: one-cycle pulse on the last bit of the last data symbol

## Operation
- **Handshake.** A frame is accepted on the rising edge where `valid_i && ready_o`. `ready_o` equals (state == ST_IDLE). The accepted `data_i` is captured into an internal frame register. `data_i` may change after acceptance.
- **Line format.** The line runs continuously, one bit per cycle, LSB first within each symbol. A symbol is `{K, data}`, so bit 0 is data[0] and bit `SYM_W-1` is K. Symbol index 0 is sent first.
- **Symbol boundary.** The boundary is the cycle where the bit counter is 0. Each symbol is loaded into the shifter on that cycle.
- **State machine.**
  - ST_IDLE: sends `{1'b1, COMMA}` continuously. On acceptance → ST_ARMED.
  - ST_ARMED: finishes the current idle comma. At the next boundary → ST_PRE.
  - ST_PRE: sends `NUM_COMMAS` commas. After the last bit of the last preamble comma → ST_DATA.
  - ST_DATA: sends symbols 0..`NUM_SYMS-1` from the frame register. On the last bit of the last symbol, `done_o` is 1 and the next state is ST_IDLE.
- **Back-to-back frames.** A new frame can be accepted in the first ST_IDLE cycle. It therefore starts after exactly one idle comma.
- **`busy_o`.** Equals (state != ST_IDLE).
- **Counters.**
  - Bit counter: 0..`SYM_W-1`, wraps to 0.
  - Symbol counter: width `$clog2(max(NUM_SYMS,NUM_COMMAS)+1)`, cleared on every state change.
- **Parameter check.** An elaboration-time assertion fails if `NUM_SYMS<1`, `NUM_COMMAS<1` or `DATA_W<1`.

## Timing
- **Reset values** (while `rst_ni`=0, sampled): `data_o`=0, `ena_o`=0, `ready_o`=0, `busy_o`=0, `done_o`=0, state ST_IDLE, bit counter 0.
- **First cycle after reset release:** `ena_o`=1 and `data_o`=COMMA[0]. `ready_o`=1 from this cycle.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs to outputs.
- **Acceptance latency:** if acceptance happens while bit b of an idle comma is on the line, the preamble's first bit appears `SYM_W-b` cycles later.
- **Frame length:** `(NUM_COMMAS+NUM_SYMS)*SYM_W` cycles from the preamble's first bit to the `done_o` cycle inclusive. With defaults this is 36.
- **Reset mid-frame:** the frame is discarded. Outputs return to reset values the next cycle. After release the line restarts with idle commas.
- **`valid_i` while not ready:** ignored, with no capture. The frame register holds its value for the whole frame.

## Structure
- **Package `serdes_pkg`:**
  - state enum `fs_state_e` {ST_IDLE, ST_ARMED, ST_PRE, ST_DATA};
  - `COMMA_DEFAULT` = 8'h3C;
  - `KCODE` = 1'b1;
  - function `sym_w(data_w)`.
- **Sub-module `sym_shifter`** (parameter `SYM_W`), instantiated once:
  - loads a symbol on `load_i` and shifts it out LSB first;
  - holds the bit counter;
  - drives `data_o`, `ena_o` (first bit) and `last_o` (bit `SYM_W-1`);
  - reset uses `rst_ni`.
- **Top level:** holds the FSM, the frame register, the symbol counter and the next-symbol multiplexer.

## Test plan
- **Reset/idle, defaults:** release reset and watch 5 symbols. Required: repeating 9-bit pattern 0,0,1,1,1,1,0,0,1 (0x13C LSB first); `ena_o` every 9 cycles; `ready_o`=1; `busy_o`=0.
- **Single frame, defaults:** `data_i`={9'h0AA, 9'h055, 9'h1BC} with valid for 1 cycle at bit 3 of an idle comma. Required:
  - preamble starts 6 cycles later;
  - then symbols 0x1BC, 0x055, 0x0AA;
  - `done_o` on the last bit of 0x0AA;
  - 36 cycles from preamble start to `done_o`;
  - `busy_o` high from acceptance to `done_o`.
- **Backpressure:** hold `valid_i`=1 with two different frames. Required: second accepted in the first ST_IDLE cycle after `done_o`; exactly one idle comma between frames; first frame unaffected by `data_i` changes.
- **Parametrised, `NUM_SYMS`=5, `DATA_W`=10, `NUM_COMMAS`=2:** frame of incrementing values 0x001..0x005, K=0. Required: 2 commas `{1,COMMA}` then 5 × 11-bit symbols; `done_o` 77 cycles after preamble start.
- **Reset mid-frame:** assert `rst_ni`=0 during data symbol 1 for 2 cycles. Required:
  - all outputs 0 during reset;
  - after release, the idle comma restarts at bit 0;
  - no `done_o`;
  - `ready_o`=1.
- **K-flag passthrough:** symbol `{1'b1, 8'hFB}` in slot 2. Required: bit 8 of the third data symbol is 1.
